// File: rtl/pe_array_ctrl.sv
// Layer sequencer for pe_array_top: clear, weight load, input load, drain, write-back.
// Optional read watchdog enabled by defining PE_CTRL_TIMEOUT_EN.
module pe_array_ctrl #(
  parameter int DRAIN_CYCLES = 8,
  parameter int WR_GAP       = 64,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  cfg_conv_num,
  input  logic        cfg_relu_en,
  input  logic        cfg_pool_en,
  input  logic        cfg_partial_en,
  input  logic [16:0] cfg_w_base,
  input  logic [16:0] cfg_w_cnt,
  input  logic [16:0] cfg_i_base,
  input  logic [16:0] cfg_i_cnt,
  input  logic [14:0] cfg_o_base,
  input  logic [14:0] cfg_o_cnt,
  input  logic        readdatavalid_out_weight,
  input  logic        readdatavalid_out_input,
  output logic [3:0]  conv_num,
  output logic        relu_en_control,
  output logic        pool_en_control,
  output logic        partial_en_control,
  output logic        output_en_control,
  output logic        rst_n_pe,
  output logic        en_readw_control,
  output logic [16:0] addr_readw_control,
  output logic        en_readi_control,
  output logic [16:0] addr_readi_control,
  output logic        en_write_control,
  output logic [14:0] addr_write_control,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CLEAR  = 4'd1;
  localparam logic [3:0] S_W_REQ  = 4'd2;
  localparam logic [3:0] S_W_WAIT = 4'd3;
  localparam logic [3:0] S_I_REQ  = 4'd4;
  localparam logic [3:0] S_I_WAIT = 4'd5;
  localparam logic [3:0] S_DRAIN  = 4'd6;
  localparam logic [3:0] S_WR_REQ = 4'd7;
  localparam logic [3:0] S_WR_GAP = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
  localparam logic [3:0] S_ERR    = 4'd10;

  logic [3:0]  state_r, state_nxt_s;
  logic [16:0] idx_r, idx_nxt_s;
  logic [31:0] cyc_r, cyc_nxt_s;
  logic        accept_s;
  logic [3:0]  conv_num_r;
  logic        relu_r, pool_r, partial_r, out_en_r, rst_n_pe_r;
  logic [16:0] w_base_r, w_cnt_r, i_base_r, i_cnt_r;
  logic [14:0] o_base_r, o_cnt_r;
  logic        en_readw_r, en_readi_r, en_write_r, busy_r, done_r, error_r;
  logic [16:0] addr_readw_r, addr_readi_r;
  logic [14:0] addr_write_r;

  assign accept_s = (state_r == S_IDLE) && start && !busy_r;

  // Next-state, shared phase index and cycle counter.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cyc_nxt_s   = cyc_r;
    case (state_r)
      S_IDLE: begin
        idx_nxt_s = 17'd0;
        cyc_nxt_s = 32'd0;
        if (accept_s) state_nxt_s = S_CLEAR;
        else          state_nxt_s = S_IDLE;
      end
      S_CLEAR: begin
        idx_nxt_s = 17'd0;
        cyc_nxt_s = 32'd0;
        if (w_cnt_r != 17'd0)      state_nxt_s = S_W_REQ;
        else if (i_cnt_r != 17'd0) state_nxt_s = S_I_REQ;
        else                       state_nxt_s = S_DRAIN;
      end
      S_W_REQ: begin
        cyc_nxt_s   = 32'd0;
        state_nxt_s = S_W_WAIT;
      end
      S_W_WAIT: begin
        if (readdatavalid_out_weight) begin
          cyc_nxt_s = 32'd0;
          if (idx_r + 17'd1 == w_cnt_r) begin
            idx_nxt_s = 17'd0;
            if (i_cnt_r != 17'd0) state_nxt_s = S_I_REQ;
            else                  state_nxt_s = S_DRAIN;
          end else begin
            idx_nxt_s   = idx_r + 17'd1;
            state_nxt_s = S_W_REQ;
          end
        end
`ifdef PE_CTRL_TIMEOUT_EN
        else if (cyc_r == 32'(TIMEOUT - 1)) begin
          cyc_nxt_s   = 32'd0;
          state_nxt_s = S_ERR;
        end
`endif
        else begin
          cyc_nxt_s = cyc_r + 32'd1;
        end
      end
      S_I_REQ: begin
        cyc_nxt_s   = 32'd0;
        state_nxt_s = S_I_WAIT;
      end
      S_I_WAIT: begin
        if (readdatavalid_out_input) begin
          cyc_nxt_s = 32'd0;
          if (idx_r + 17'd1 == i_cnt_r) begin
            idx_nxt_s   = 17'd0;
            state_nxt_s = S_DRAIN;
          end else begin
            idx_nxt_s   = idx_r + 17'd1;
            state_nxt_s = S_I_REQ;
          end
        end
`ifdef PE_CTRL_TIMEOUT_EN
        else if (cyc_r == 32'(TIMEOUT - 1)) begin
          cyc_nxt_s   = 32'd0;
          state_nxt_s = S_ERR;
        end
`endif
        else begin
          cyc_nxt_s = cyc_r + 32'd1;
        end
      end
      S_DRAIN: begin
        if (cyc_r == 32'(DRAIN_CYCLES - 1)) begin
          cyc_nxt_s = 32'd0;
          idx_nxt_s = 17'd0;
          if (o_cnt_r != 15'd0) state_nxt_s = S_WR_REQ;
          else                  state_nxt_s = S_DONE;
        end else begin
          cyc_nxt_s = cyc_r + 32'd1;
        end
      end
      S_WR_REQ: begin
        cyc_nxt_s   = 32'd0;
        state_nxt_s = S_WR_GAP;
      end
      S_WR_GAP: begin
        // WR_REQ consumes one cycle of each write slot, the gap the remaining WR_GAP-1.
        if (cyc_r == 32'(WR_GAP - 2)) begin
          cyc_nxt_s = 32'd0;
          if (idx_r[14:0] + 15'd1 == o_cnt_r) begin
            idx_nxt_s   = 17'd0;
            state_nxt_s = S_DONE;
          end else begin
            idx_nxt_s   = idx_r + 17'd1;
            state_nxt_s = S_WR_REQ;
          end
        end else begin
          cyc_nxt_s = cyc_r + 32'd1;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      S_ERR:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, configuration shadow and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      idx_r        <= 17'd0;
      cyc_r        <= 32'd0;
      conv_num_r   <= 4'd0;
      relu_r       <= 1'b0;
      pool_r       <= 1'b0;
      partial_r    <= 1'b0;
      w_base_r     <= 17'd0;
      w_cnt_r      <= 17'd0;
      i_base_r     <= 17'd0;
      i_cnt_r      <= 17'd0;
      o_base_r     <= 15'd0;
      o_cnt_r      <= 15'd0;
      out_en_r     <= 1'b0;
      rst_n_pe_r   <= 1'b1;
      en_readw_r   <= 1'b0;
      en_readi_r   <= 1'b0;
      en_write_r   <= 1'b0;
      addr_readw_r <= 17'd0;
      addr_readi_r <= 17'd0;
      addr_write_r <= 15'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      cyc_r   <= cyc_nxt_s;
      if (accept_s) begin
        conv_num_r <= cfg_conv_num;
        relu_r     <= cfg_relu_en;
        pool_r     <= cfg_pool_en;
        partial_r  <= cfg_partial_en;
        w_base_r   <= cfg_w_base;
        w_cnt_r    <= cfg_w_cnt;
        i_base_r   <= cfg_i_base;
        i_cnt_r    <= cfg_i_cnt;
        o_base_r   <= cfg_o_base;
        o_cnt_r    <= cfg_o_cnt;
      end
      rst_n_pe_r <= (state_nxt_s != S_CLEAR);
      out_en_r   <= (state_nxt_s == S_WR_REQ) || (state_nxt_s == S_WR_GAP);
      en_readw_r <= (state_nxt_s == S_W_REQ);
      en_readi_r <= (state_nxt_s == S_I_REQ);
      en_write_r <= (state_nxt_s == S_WR_REQ);
      if (state_nxt_s == S_W_REQ)  addr_readw_r <= w_base_r + idx_nxt_s;
      if (state_nxt_s == S_I_REQ)  addr_readi_r <= i_base_r + idx_nxt_s;
      if (state_nxt_s == S_WR_REQ) addr_write_r <= o_base_r + idx_nxt_s[14:0];
      // done trails the DONE state by one cycle; busy drops the cycle after done.
      done_r <= (state_r == S_DONE);
      if (accept_s)                busy_r <= 1'b1;
      else if (done_r)             busy_r <= 1'b0;
      else if (state_r == S_ERR)   busy_r <= 1'b0;
      if (accept_s)                error_r <= 1'b0;
      else if (state_nxt_s == S_ERR) error_r <= 1'b1;
    end
  end

  assign conv_num           = conv_num_r;
  assign relu_en_control    = relu_r;
  assign pool_en_control    = pool_r;
  assign partial_en_control = partial_r;
  assign output_en_control  = out_en_r;
  assign rst_n_pe           = rst_n_pe_r;
  assign en_readw_control   = en_readw_r;
  assign addr_readw_control = addr_readw_r;
  assign en_readi_control   = en_readi_r;
  assign addr_readi_control = addr_readi_r;
  assign en_write_control   = en_write_r;
  assign addr_write_control = addr_write_r;
  assign busy               = busy_r;
  assign done               = done_r;
`ifdef PE_CTRL_TIMEOUT_EN
  assign error = error_r;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed self-checking bench for pe_array_ctrl (DRAIN_CYCLES=4, WR_GAP=4, TIMEOUT=16).
module tb_pe_array_ctrl;
  localparam int DC = 4;
  localparam int WG = 4;
  localparam int TO = 16;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0]  cfg_conv_num = 4'd0;
  logic        cfg_relu_en = 1'b0, cfg_pool_en = 1'b0, cfg_partial_en = 1'b0;
  logic [16:0] cfg_w_base = 17'd0, cfg_w_cnt = 17'd0, cfg_i_base = 17'd0, cfg_i_cnt = 17'd0;
  logic [14:0] cfg_o_base = 15'd0, cfg_o_cnt = 15'd0;
  logic        readdatavalid_out_weight = 1'b0, readdatavalid_out_input = 1'b0;
  logic [3:0]  conv_num;
  logic        relu_en_control, pool_en_control, partial_en_control, output_en_control;
  logic        rst_n_pe, en_readw_control, en_readi_control, en_write_control;
  logic [16:0] addr_readw_control, addr_readi_control;
  logic [14:0] addr_write_control;
  logic        busy, done, error;

  pe_array_ctrl #(.DRAIN_CYCLES(DC), .WR_GAP(WG), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_conv_num(cfg_conv_num), .cfg_relu_en(cfg_relu_en), .cfg_pool_en(cfg_pool_en),
    .cfg_partial_en(cfg_partial_en),
    .cfg_w_base(cfg_w_base), .cfg_w_cnt(cfg_w_cnt), .cfg_i_base(cfg_i_base), .cfg_i_cnt(cfg_i_cnt),
    .cfg_o_base(cfg_o_base), .cfg_o_cnt(cfg_o_cnt),
    .readdatavalid_out_weight(readdatavalid_out_weight), .readdatavalid_out_input(readdatavalid_out_input),
    .conv_num(conv_num), .relu_en_control(relu_en_control), .pool_en_control(pool_en_control),
    .partial_en_control(partial_en_control), .output_en_control(output_en_control),
    .rst_n_pe(rst_n_pe),
    .en_readw_control(en_readw_control), .addr_readw_control(addr_readw_control),
    .en_readi_control(en_readi_control), .addr_readi_control(addr_readi_control),
    .en_write_control(en_write_control), .addr_write_control(addr_write_control),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: logs every enable pulse, PE clear cycle and done pulse.
  logic [16:0] w_log [0:255];
  logic [16:0] i_log [0:255];
  logic [14:0] o_log [0:255];
  int  w_n = 0, i_n = 0, o_n = 0, clr_n = 0, done_n = 0;
  time t_done = 0;

  always @(negedge clk) begin
    if (en_readw_control && w_n < 256) begin w_log[w_n] = addr_readw_control; w_n++; end
    if (en_readi_control && i_n < 256) begin i_log[i_n] = addr_readi_control; i_n++; end
    if (en_write_control && o_n < 256) begin o_log[o_n] = addr_write_control; o_n++; end
    if (!rst_n_pe) clr_n++;
    if (done) begin done_n++; t_done = $time; end
  end

  // Read-master model: strobe two cycles after each request.
  int w_pend = 0, i_pend = 0;
  bit stray_mode = 1'b0;
  bit resp_w_on  = 1'b1;

  always @(negedge clk) begin
    readdatavalid_out_weight = 1'b0;
    readdatavalid_out_input  = 1'b0;
    if (w_pend > 0) begin
      w_pend--;
      if (w_pend == 0) begin
        readdatavalid_out_weight = 1'b1;
        if (stray_mode) readdatavalid_out_input = 1'b1;
      end
    end
    if (i_pend > 0) begin
      i_pend--;
      if (i_pend == 0) readdatavalid_out_input = 1'b1;
    end
    if (en_readw_control && resp_w_on) w_pend = 2;
    if (en_readi_control) i_pend = 2;
  end

  int  w0, i0, o0, c0, d_base;
  time t_start;

  task automatic set_cfg(input logic [3:0] cn, input logic [2:0] modes,
                         input logic [16:0] wb, input logic [16:0] wc,
                         input logic [16:0] ib, input logic [16:0] ic,
                         input logic [14:0] ob, input logic [14:0] oc);
    cfg_conv_num = cn;
    {cfg_relu_en, cfg_pool_en, cfg_partial_en} = modes;
    cfg_w_base = wb; cfg_w_cnt = wc;
    cfg_i_base = ib; cfg_i_cnt = ic;
    cfg_o_base = ob; cfg_o_cnt = oc;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    w0 = w_n; i0 = i_n; o0 = o_n; c0 = clr_n; d_base = done_n;
    start = 1'b1;
    t_start = $time;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_n == d_base && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    check_val({tag, "_done_seen"}, 32'(done_n != d_base), 32'd1);
  endtask

  task automatic run_basic(input string tag);
    set_cfg(4'd3, 3'b101, 17'h00100, 17'd3, 17'h00200, 17'd2, 15'h0010, 15'd2);
    pulse_start();
    check_val({tag, "_busy_rise"}, 32'(busy), 32'd1);
    check_val({tag, "_modes"}, {28'd0, conv_num}, 32'd3);
    check_val({tag, "_mode_bits"}, 32'({relu_en_control, pool_en_control, partial_en_control}), 32'b101);
    wait_done(tag);
    check_val({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check_val({tag, "_start_to_done"}, 32'((t_done - t_start) / 10), 32'd30);
    check_val({tag, "_w_cnt"}, 32'(w_n - w0), 32'd3);
    for (int k = 0; k < 3; k++) check_val({tag, "_w_addr"}, 32'(w_log[w0 + k]), 32'h100 + 32'(k));
    check_val({tag, "_i_cnt"}, 32'(i_n - i0), 32'd2);
    for (int k = 0; k < 2; k++) check_val({tag, "_i_addr"}, 32'(i_log[i0 + k]), 32'h200 + 32'(k));
    check_val({tag, "_o_cnt"}, 32'(o_n - o0), 32'd2);
    for (int k = 0; k < 2; k++) check_val({tag, "_o_addr"}, 32'(o_log[o0 + k]), 32'h10 + 32'(k));
    check_val({tag, "_clr_cycles"}, 32'(clr_n - c0), 32'd1);
    @(negedge clk); #1;
    check_val({tag, "_busy_fall"}, 32'({busy, done}), 32'd0);
    check_val({tag, "_done_pulses"}, 32'(done_n - d_base), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("reset_ctrl", 32'({busy, done, error, en_readw_control, en_readi_control, en_write_control,
                                 rst_n_pe, relu_en_control, pool_en_control, partial_en_control,
                                 output_en_control, conv_num}), 32'b000000100000000);
    check_val("reset_addr_w", 32'(addr_readw_control), 32'd0);
    check_val("reset_addr_i", 32'(addr_readi_control), 32'd0);
    check_val("reset_addr_o", 32'(addr_write_control), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_basic("basic");

    // All counts zero: CLEAR -> DRAIN -> DONE with no enable pulses.
    set_cfg(4'd1, 3'b000, 17'h00100, 17'd0, 17'h00200, 17'd0, 15'h0010, 15'd0);
    pulse_start();
    wait_done("zero");
    check_val("zero_start_to_done", 32'((t_done - t_start) / 10), 32'(3 + DC));
    check_val("zero_no_en", 32'((w_n - w0) + (i_n - i0) + (o_n - o0)), 32'd0);
    check_val("zero_clr_cycles", 32'(clr_n - c0), 32'd1);
    repeat (2) @(negedge clk);

    // Input address wraps at 17 bits.
    set_cfg(4'd2, 3'b010, 17'h00000, 17'd0, 17'h1FFFF, 17'd2, 15'h0000, 15'd0);
    pulse_start();
    wait_done("wrap");
    check_val("wrap_i_cnt", 32'(i_n - i0), 32'd2);
    check_val("wrap_i_addr0", 32'(i_log[i0]), 32'h1FFFF);
    check_val("wrap_i_addr1", 32'(i_log[i0 + 1]), 32'h00000);
    repeat (2) @(negedge clk);

    // Stray input strobes with each weight strobe, and a second start while busy.
    stray_mode = 1'b1;
    set_cfg(4'd5, 3'b000, 17'h00040, 17'd2, 17'h00080, 17'd1, 15'h0005, 15'd1);
    pulse_start();
    repeat (4) @(negedge clk);
    set_cfg(4'd9, 3'b111, 17'h00000, 17'd7, 17'h00000, 17'd7, 15'h0000, 15'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("robust");
    stray_mode = 1'b0;
    check_val("robust_w_cnt", 32'(w_n - w0), 32'd2);
    check_val("robust_i_cnt", 32'(i_n - i0), 32'd1);
    check_val("robust_i_addr", 32'(i_log[i0]), 32'h80);
    check_val("robust_o_cnt", 32'(o_n - o0), 32'd1);
    check_val("robust_conv_num", {28'd0, conv_num}, 32'd5);
    repeat (10) @(negedge clk);
    check_val("robust_no_rerun", 32'((w_n - w0) + (done_n - d_base)), 32'd3);

    // Reset asserted in I_WAIT.
    set_cfg(4'd6, 3'b111, 17'h00000, 17'd1, 17'h00300, 17'd3, 15'h0000, 15'd1);
    pulse_start();
    for (int k = 0; k < 100 && i_n == i0; k++) begin @(negedge clk); #1; end
    check_val("rstmid_reached_i", 32'(i_n - i0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rstmid_ctrl", 32'({busy, done, error, en_readw_control, en_readi_control, en_write_control,
                                   rst_n_pe, relu_en_control, pool_en_control, partial_en_control,
                                   output_en_control, conv_num}), 32'b000000100000000);
    check_val("rstmid_addr_i", 32'(addr_readi_control), 32'd0);
    check_val("rstmid_addr_w", 32'(addr_readw_control), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_basic("after_rst");

`ifdef PE_CTRL_TIMEOUT_EN
    // Withheld weight strobe trips the watchdog.
    resp_w_on = 1'b0;
    set_cfg(4'd4, 3'b000, 17'h00000, 17'd1, 17'h00000, 17'd0, 15'h0000, 15'd0);
    pulse_start();
    for (int k = 0; k < 60 && !error; k++) begin @(negedge clk); #1; end
    check_val("timeout_error", 32'(error), 32'd1);
    check_val("timeout_elapsed", 32'((($time - 1) - t_start) / 10), 32'd19);
    @(negedge clk); #1;
    check_val("timeout_idle", 32'({busy, error}), 32'b01);
    repeat (5) @(negedge clk);
    check_val("timeout_no_done", 32'(done_n - d_base), 32'd0);
    resp_w_on = 1'b1;
    set_cfg(4'd1, 3'b000, 17'h00000, 17'd0, 17'h00000, 17'd0, 15'h0000, 15'd0);
    pulse_start();
    check_val("timeout_err_cleared", 32'(error), 32'd0);
    wait_done("after_timeout");
`else
    check_val("error_tied_low", 32'(error), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Layer sequencer for `pe_array_top`. It latches one convolution job's configuration on `start`, then runs the job in a fixed order: PE clear, weight/bias load, input-feature load, pipeline drain, output write-back. It drives every `*_control` input of `pe_array_top`, plus `conv_num` and `rst_n_pe`. It paces the read phases from the read masters' `readdatavalid_out_*` strobes.

## Interface
Parameters
- `DRAIN_CYCLES`, default 8: idle cycles between the last input word and the first write.
- `WR_GAP`, default 64: cycles reserved per 1024→16 serialized write pulse.
- `TIMEOUT`, default 1024: watchdog limit, in cycles, for one read wait (macro-gated).

Ports
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle job request; ignored unless `busy`=0.
- `cfg_conv_num` in 4; `cfg_relu_en` in 1; `cfg_pool_en` in 1; `cfg_partial_en` in 1: job mode bits.
- `cfg_w_base` in 17; `cfg_w_cnt` in 17: weight/bias base address and word count.
- `cfg_i_base` in 17; `cfg_i_cnt` in 17: input-feature base address and word count.
- `cfg_o_base` in 15; `cfg_o_cnt` in 15: output base address and write-pulse count.
- `readdatavalid_out_weight` in 1; `readdatavalid_out_input` in 1: read-completion strobes.
- `conv_num` out 4; `relu_en_control`, `pool_en_control`, `partial_en_control`, `output_en_control` out 1: latched mode bits.
- `rst_n_pe` out 1: active-low PE accumulator clear.
- `en_readw_control` out 1; `addr_readw_control` out 17.
- `en_readi_control` out 1; `addr_readi_control` out 17.
- `en_write_control` out 1; `addr_write_control` out 15.
- `busy` out 1; `done` out 1 (one-cycle pulse); `error` out 1 (sticky until next accepted `start`).

## Operation
- States: IDLE, CLEAR, W_REQ, W_WAIT, I_REQ, I_WAIT, DRAIN, WR_REQ, WR_GAP, DONE, ERR.
- IDLE:
  - `start` latches all `cfg_*` into shadow registers, clears `error`, and goes to CLEAR.
  - `conv_num` and the mode outputs always reflect the shadow registers.
- CLEAR: `rst_n_pe`=0 for exactly one cycle, then go to W_REQ.
- Weight load:
  - W_REQ pulses `en_readw_control` for one cycle with `addr_readw_control` = base + index, then goes to W_WAIT.
  - W_WAIT holds until `readdatavalid_out_weight`, then increments the index.
  - If index == `cfg_w_cnt`, go to I_REQ; otherwise return to W_REQ.
- Input load: I_REQ/I_WAIT behave identically on the input channel. On completion, go to DRAIN.
- DRAIN: counts `DRAIN_CYCLES`, then goes to WR_REQ.
- Write-back:
  - WR_REQ pulses `en_write_control` for one cycle with `addr_write_control` = `cfg_o_base` + index.
  - WR_GAP waits `WR_GAP`-1 cycles. After that, go to DONE if `cfg_o_cnt` pulses are done; otherwise return to WR_REQ.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Zero counts: a count of 0 skips its phase entirely, with no enable pulse. If all three counts are 0, the path is CLEAR → DRAIN → DONE.
- Address sums are taken modulo the port width (wrap, no saturation).
- A strobe arriving outside the matching WAIT state is ignored. `start` while `busy` is ignored. Simultaneous strobes: only the one matching the current state counts.
- Reset mid-job: immediate return to IDLE; all counters are cleared.

## Timing
- Reset values:
  - All `en_*`, `busy`, `done`, `error` = 0.
  - All addresses = 0; `conv_num` = 0; mode bits = 0.
  - `rst_n_pe` = 1.
- All outputs are registered.
- `busy` rises on the cycle after `start` is sampled and falls on the cycle after `done`.
- One read costs 1 request cycle plus the wait. The next `en_read*` pulse comes, at earliest, 1 cycle after the strobe is sampled.
- Zero-wait job (w=1, i=1, o=1, strobes 1 cycle after request): `start` to `done` = 1 + 1 + 2 + 2 + `DRAIN_CYCLES` + `WR_GAP` + 1 cycles.

## Configuration
- `PE_CTRL_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in W_WAIT or I_WAIT.
  - Reaching `TIMEOUT` moves to ERR: `error`=1, `busy` stays 1 for one cycle, then IDLE with no `done` pulse.
- `PE_CTRL_TIMEOUT_EN` undefined: no watchdog logic; `error` is tied to 0; the WAIT states wait indefinitely.

## Test plan
- Basic job: reset, then `start` with w_cnt=3, i_cnt=2, o_cnt=2, bases 0x100/0x200/0x10, strobes 2 cycles after each request → weight addresses 0x100–0x102, input addresses 0x200–0x201, write addresses 0x10–0x11, exactly one `done` pulse, `rst_n_pe` low for exactly 1 cycle.
- Zero counts: w_cnt=0, i_cnt=0, o_cnt=0 → no `en_*` pulses; `done` pulses 3+`DRAIN_CYCLES` cycles after `start`.
- Wrap: cfg_i_base=0x1FFFF, i_cnt=2 → addresses 0x1FFFF then 0x00000.
- Robustness: a stray `readdatavalid_out_input` during the weight phase and a second `start` while `busy` → neither changes the counts nor the latched `cfg_conv_num`.
- Reset mid-job: assert `rst` in I_WAIT → next cycle all outputs are at reset values; a new `start` runs normally.
- `PE_CTRL_TIMEOUT_EN` build with `TIMEOUT`=16: withhold the weight strobe → `error`=1 after 16 cycles, no `done` pulse, back in IDLE.
